sprite_palette_lut: RTL and testbench
=====================================

Name: sprite_palette_lut

Overview:
- Parametrised, writable colour palette for sprite pixel indices. Maps a per-pixel colour index plus a bank select to RGB through a 2-stage registered pipeline.
- Sits between the sprite ROM/address logic and the VGA colour mux.
- Adds runtime-loadable entries, multiple banks, transparency flagging, a post-reset clear sequence and a global brightness fade engine.

Parameters:
- INDEX_W, 4, colour index width; 2^INDEX_W entries per bank.
- COLOR_W, 4, bits per colour channel.
- NUM_BANKS, 4, number of palettes; BANK_W = max(1, $clog2(NUM_BANKS)).
- TRANSP_INDEX, 0, index value flagged as transparent.
- FADE_DIV, 1024, clock cycles per brightness step (≥1).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel request valid.
- pix_index  in  INDEX_W  colour index.
- pix_bank  in  BANK_W  palette bank select.
- pix_out_valid  out  1  output pixel valid.
- red  out  COLOR_W  red channel.
- green  out  COLOR_W  green channel.
- blue  out  COLOR_W  blue channel.
- transparent  out  1  output pixel index equals TRANSP_INDEX.
- wr_valid  in  1  palette write request.
- wr_ready  out  1  write accepted this cycle when high.
- wr_bank  in  BANK_W  write bank.
- wr_index  in  INDEX_W  write entry.
- wr_data  in  3*COLOR_W  {R,G,B}, R in MSBs.
- init_busy  out  1  post-reset clear in progress.
- fade_start  in  1  pulse: load fade target (FADE_EN only).
- fade_target  in  5  target brightness 0..16 (FADE_EN only).
- fade_level  out  5  current brightness; 16 = unity.
- fade_busy  out  1  fade in progress.

Behaviour:
- Clock and reset: one clock domain, Clk. Reset_n is asynchronous and active-low.
- Reset values: pix_out_valid=0, rgb=0, transparent=0, wr_ready=0, init_busy=1, fade_level=16, fade_busy=0.
- Storage: NUM_BANKS*2^INDEX_W words of 3*COLOR_W bits. Address = {bank, index}. Bank values ≥ NUM_BANKS alias modulo the BANK_W decode; the contents of those addresses are undefined.
- FSM INIT: entered on reset release.
  - A counter walks every address from 0 upward, writing 0, one entry per cycle.
  - INIT takes exactly NUM_BANKS*2^INDEX_W cycles.
  - init_busy=1 and wr_ready=0 for the whole state.
  - Moves to RUN after the last address is written.
- FSM RUN: wr_ready=1. A write with wr_valid=1 commits at that clock edge.
- Reset mid-operation: asserting Reset_n low in any state returns the FSM to INIT and restarts the clear from address 0.
- Pipeline latency is a fixed 2 cycles:
  - Stage 1 registers the RAM read, pix_valid and the transparency compare.
  - Stage 2 registers the brightness-scaled colour.
  - pix_out_valid equals pix_valid delayed by 2 cycles.
  - Requests may arrive every cycle; there is no back-pressure.
- Pixels during INIT: requests pass through the pipeline with valid timing, but rgb is forced to 0.
- Read-during-write to the same address: the read returns the old data. The new data is visible to a request issued on the next cycle.
- Transparent flag: asserted when the index equals TRANSP_INDEX, aligned with pix_out_valid. rgb is still driven with the entry contents. transparent=0 whenever pix_out_valid=0.
- Scaling: ch_out = (ch * fade_level) >> 4, computed in COLOR_W+5 bits and truncated to COLOR_W.
  - Level 16 is the identity.
  - Level 0 gives black.
- Output hold: when pix_out_valid=0, rgb is 0.

Optional Feature:
- Macro: SPRITE_PALETTE_FADE_EN.
- When defined, the fade engine is built:
  - fade_start latches min(fade_target,16) as the target and clears the divider.
  - Every FADE_DIV cycles, fade_level steps by 1 toward the target.
  - fade_busy=1 while fade_level ≠ target.
  - fade_start while busy retargets immediately and restarts the divider.
  - A target equal to the current level leaves fade_busy=0.
  - fade_start is ignored during INIT.
- When undefined:
  - fade_level is tied to 16 and fade_busy to 0.
  - fade_start and fade_target are ignored.
  - No multiplier is synthesised, but latency stays 2 cycles.

Test Plan:
- Reset release, NUM_BANKS=4, INDEX_W=4 -> init_busy high exactly 64 cycles, wr_ready low throughout; all reads during and after INIT return rgb 0.
- Write bank2/index5 = 12'hF91, then issue pix_bank=2, pix_index=5 -> 2 cycles later pix_out_valid=1, red=F, green=9, blue=1, transparent=0.
- Back-to-back reads, one per cycle, alternating index 0 and 5 over 8 cycles -> 8 consecutive valid outputs in order. Index 0 outputs have transparent=1.
- Write and read the same address in one cycle (old 12'h000, new 12'hABC) -> that read returns 000; a read on the next cycle returns ABC.
- FADE_EN, FADE_DIV=4, entry 12'hFFF, fade_start with target 8 -> fade_level falls by 1 every 4 cycles, reaching 8 after 32 cycles. At level 8, red=green=blue=7 ((15*8)>>4). fade_busy then drops.
- Reset_n asserted mid-write-stream and mid-fade -> outputs return to reset values, INIT restarts from address 0, earlier writes are cleared, fade_level=16.

Source files
------------

// File: rtl/sprite_palette_lut.sv
// Banked, runtime-writable sprite palette with a 2-cycle registered read path, post-reset clear
// and an optional global brightness fade engine (built when SPRITE_PALETTE_FADE_EN is defined).
module sprite_palette_lut #(
  parameter int unsigned INDEX_W      = 4,
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned TRANSP_INDEX = 0,
  parameter int unsigned FADE_DIV     = 1024,
  localparam int unsigned BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   pix_valid,
  input  logic [INDEX_W-1:0]     pix_index,
  input  logic [BANK_W-1:0]      pix_bank,
  output logic                   pix_out_valid,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   transparent,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [BANK_W-1:0]      wr_bank,
  input  logic [INDEX_W-1:0]     wr_index,
  input  logic [3*COLOR_W-1:0]   wr_data,
  output logic                   init_busy,
  input  logic                   fade_start,
  input  logic [4:0]             fade_target,
  output logic [4:0]             fade_level,
  output logic                   fade_busy
);

  localparam int unsigned AddrW     = BANK_W + INDEX_W;
  localparam int unsigned InitDepth = NUM_BANKS * (2 ** INDEX_W);
  localparam int unsigned DataW     = 3 * COLOR_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == AddrW'(InitDepth - 1)) begin
          state_d    = StRun;
          init_cnt_d = '0;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign init_busy = (state_q == StInit);
  assign wr_ready  = (state_q == StRun);

  // Palette storage; the clear sequence owns the write port during INIT.
  logic [DataW-1:0] mem_q [2**AddrW];
  logic             mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [DataW-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_cnt_q;
    mem_wdata = '0;
    if (state_q == StInit) begin
      mem_we = 1'b1;
    end else if (wr_valid) begin
      mem_we    = 1'b1;
      mem_waddr = {wr_bank, wr_index};
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Stage 1: the read samples pre-write contents, giving read-old-data on a collision.
  logic             s1_valid_q, s1_transp_q, s1_transp_d;
  logic [DataW-1:0] s1_rgb_q, s1_rgb_d;
  logic [AddrW-1:0] rd_addr;

  always_comb begin
    rd_addr     = {pix_bank, pix_index};
    s1_rgb_d    = (state_q == StRun) ? mem_q[rd_addr] : '0;
    s1_transp_d = (pix_index == INDEX_W'(TRANSP_INDEX));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_transp_q <= 1'b0;
      s1_rgb_q    <= '0;
    end else begin
      s1_valid_q  <= pix_valid;
      s1_transp_q <= s1_transp_d;
      s1_rgb_q    <= s1_rgb_d;
    end
  end

  logic [DataW-1:0] scaled_rgb;

`ifdef SPRITE_PALETTE_FADE_EN
  localparam int unsigned DivW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [4:0]      level_q, level_d, tgt_q, tgt_d;
  logic [DivW-1:0] div_q, div_d;

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] ch,
                                               input logic [4:0]         lvl);
    logic [COLOR_W+4:0] prod;
    prod = (COLOR_W+5)'(ch) * (COLOR_W+5)'(lvl);
    return COLOR_W'(prod >> 4);
  endfunction

  always_comb begin
    level_d = level_q;
    tgt_d   = tgt_q;
    div_d   = div_q;
    if (fade_start && (state_q == StRun)) begin
      tgt_d = (fade_target > 5'd16) ? 5'd16 : fade_target;
      div_d = '0;
    end else if (level_q != tgt_q) begin
      if (div_q == DivW'(FADE_DIV - 1)) begin
        div_d   = '0;
        level_d = (level_q < tgt_q) ? level_q + 5'd1 : level_q - 5'd1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      level_q <= 5'd16;
      tgt_q   <= 5'd16;
      div_q   <= '0;
    end else begin
      level_q <= level_d;
      tgt_q   <= tgt_d;
      div_q   <= div_d;
    end
  end

  assign fade_level = level_q;
  assign fade_busy  = (level_q != tgt_q);
  assign scaled_rgb = {scale(s1_rgb_q[DataW-1 -: COLOR_W], level_q),
                       scale(s1_rgb_q[2*COLOR_W-1 -: COLOR_W], level_q),
                       scale(s1_rgb_q[COLOR_W-1:0], level_q)};
`else
  logic unused_fade;
  assign unused_fade = ^{fade_start, fade_target};
  assign fade_level  = 5'd16;
  assign fade_busy   = 1'b0;
  assign scaled_rgb  = s1_rgb_q;
`endif

  // Stage 2: colour is held at zero whenever the output is not valid.
  logic             out_valid_q, out_transp_q, out_transp_d;
  logic [DataW-1:0] out_rgb_q, out_rgb_d;

  always_comb begin
    out_rgb_d    = s1_valid_q ? scaled_rgb : '0;
    out_transp_d = s1_valid_q & s1_transp_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q  <= 1'b0;
      out_transp_q <= 1'b0;
      out_rgb_q    <= '0;
    end else begin
      out_valid_q  <= s1_valid_q;
      out_transp_q <= out_transp_d;
      out_rgb_q    <= out_rgb_d;
    end
  end

  assign pix_out_valid = out_valid_q;
  assign transparent   = out_transp_q;
  assign red           = out_rgb_q[DataW-1 -: COLOR_W];
  assign green         = out_rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue          = out_rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed self-checking bench for sprite_palette_lut; fade checks adapt to SPRITE_PALETTE_FADE_EN.
module tb_sprite_palette_lut;

  localparam int unsigned INDEX_W   = 4;
  localparam int unsigned COLOR_W   = 4;
  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned BANK_W    = 2;
  localparam int unsigned FADE_DIV  = 4;

  logic                 Clk = 1'b0;
  logic                 Reset_n;
  logic                 pix_valid;
  logic [INDEX_W-1:0]   pix_index;
  logic [BANK_W-1:0]    pix_bank;
  logic                 pix_out_valid;
  logic [COLOR_W-1:0]   red, green, blue;
  logic                 transparent;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [BANK_W-1:0]    wr_bank;
  logic [INDEX_W-1:0]   wr_index;
  logic [3*COLOR_W-1:0] wr_data;
  logic                 init_busy;
  logic                 fade_start;
  logic [4:0]           fade_target;
  logic [4:0]           fade_level;
  logic                 fade_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  sprite_palette_lut #(
    .INDEX_W     (INDEX_W),
    .COLOR_W     (COLOR_W),
    .NUM_BANKS   (NUM_BANKS),
    .TRANSP_INDEX(0),
    .FADE_DIV    (FADE_DIV)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .pix_valid    (pix_valid),
    .pix_index    (pix_index),
    .pix_bank     (pix_bank),
    .pix_out_valid(pix_out_valid),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .transparent  (transparent),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_bank      (wr_bank),
    .wr_index     (wr_index),
    .wr_data      (wr_data),
    .init_busy    (init_busy),
    .fade_start   (fade_start),
    .fade_target  (fade_target),
    .fade_level   (fade_level),
    .fade_busy    (fade_busy)
  );

  task automatic clear_inputs();
    pix_valid   = 1'b0;
    pix_index   = '0;
    pix_bank    = '0;
    wr_valid    = 1'b0;
    wr_bank     = '0;
    wr_index    = '0;
    wr_data     = '0;
    fade_start  = 1'b0;
    fade_target = '0;
  endtask

  // Counts INIT samples from the release edge onward; entered at a negedge.
  task automatic run_init(input string tag, output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 200 && init_busy === 1'b1; k++) begin
      busy_cycles++;
      n_checks++;
      if (wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wr_ready_in_init: got %b expected 0", tag, wr_ready);
      end
      if (pix_out_valid === 1'b1) begin
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
          n_fail++;
          $display("FAIL %s rgb_in_init: got %h expected 000", tag, {red, green, blue});
        end
      end
      @(negedge Clk);
      fade_start = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({pix_out_valid, red, green, blue, transparent} !== 14'h0) begin
      n_fail++;
      $display("FAIL %s out_reset: got v=%b rgb=%h t=%b expected 0/000/0", tag, pix_out_valid,
               {red, green, blue}, transparent);
    end
    n_checks++;
    if ({wr_ready, init_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s ctl_reset: got wr_ready=%b init_busy=%b expected 0/1", tag, wr_ready,
               init_busy);
    end
    n_checks++;
    if ({fade_level, fade_busy} !== {5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL %s fade_reset: got level=%0d busy=%b expected 16/0", tag, fade_level,
               fade_busy);
    end
  endtask

  task automatic test_reset();
    int busy_cycles;
    clear_inputs();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_values("reset");
    Reset_n   = 1'b1;
    pix_valid = 1'b1;
    pix_bank  = 2'd2;
    pix_index = 4'd5;
    run_init("reset", busy_cycles);
    n_checks++;
    if (busy_cycles != 64) begin
      n_fail++;
      $display("FAIL init_length: got %0d cycles expected 64", busy_cycles);
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ready_run: got %b expected 1", wr_ready);
    end
    repeat (2) @(negedge Clk);
    n_checks++;
    if (pix_out_valid !== 1'b1 || {red, green, blue} !== 12'h000) begin
      n_fail++;
      $display("FAIL read_after_init: got v=%b rgb=%h expected 1/000", pix_out_valid,
               {red, green, blue});
    end
    clear_inputs();
    @(negedge Clk);
  endtask

  task automatic test_write_read();
    wr_valid = 1'b1;
    wr_bank  = 2'd2;
    wr_index = 4'd5;
    wr_data  = 12'hF91;
    @(negedge Clk);
    wr_valid  = 1'b0;
    pix_valid = 1'b1;
    pix_bank  = 2'd2;
    pix_index = 4'd5;
    @(negedge Clk);
    pix_valid = 1'b0;
    n_checks++;
    if (pix_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got valid=%b expected 0 one cycle after request",
               pix_out_valid);
    end
    @(negedge Clk);
    n_checks++;
    if ({pix_out_valid, red, green, blue, transparent} !== {1'b1, 12'hF91, 1'b0}) begin
      n_fail++;
      $display("FAIL write_read: got v=%b rgb=%h t=%b expected 1/F91/0", pix_out_valid,
               {red, green, blue}, transparent);
    end
    @(negedge Clk);
    n_checks++;
    if ({pix_out_valid, red, green, blue, transparent} !== 14'h0) begin
      n_fail++;
      $display("FAIL output_hold: got v=%b rgb=%h t=%b expected 0/000/0", pix_out_valid,
               {red, green, blue}, transparent);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_rgb;
    logic        exp_t;
    wr_valid = 1'b1;
    wr_bank  = 2'd2;
    wr_index = 4'd0;
    wr_data  = 12'h123;
    @(negedge Clk);
    wr_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        exp_rgb = ((k - 2) % 2 == 0) ? 12'h123 : 12'hF91;
        exp_t   = ((k - 2) % 2 == 0);
        n_checks++;
        if ({pix_out_valid, red, green, blue, transparent} !== {1'b1, exp_rgb, exp_t}) begin
          n_fail++;
          $display("FAIL b2b_%0d: got v=%b rgb=%h t=%b expected 1/%h/%b", k - 2, pix_out_valid,
                   {red, green, blue}, transparent, exp_rgb, exp_t);
        end
      end
      if (k < 8) begin
        pix_valid = 1'b1;
        pix_bank  = 2'd2;
        pix_index = (k % 2 == 0) ? 4'd0 : 4'd5;
      end else begin
        pix_valid = 1'b0;
      end
      @(negedge Clk);
    end
    n_checks++;
    if (pix_out_valid !== 1'b0 || transparent !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_tail: got v=%b t=%b expected 0/0", pix_out_valid, transparent);
    end
  endtask

  task automatic test_read_during_write();
    wr_valid  = 1'b1;
    wr_bank   = 2'd1;
    wr_index  = 4'd3;
    wr_data   = 12'hABC;
    pix_valid = 1'b1;
    pix_bank  = 2'd1;
    pix_index = 4'd3;
    @(negedge Clk);
    wr_valid = 1'b0;
    @(negedge Clk);
    pix_valid = 1'b0;
    n_checks++;
    if (pix_out_valid !== 1'b1 || {red, green, blue} !== 12'h000) begin
      n_fail++;
      $display("FAIL rdw_old: got v=%b rgb=%h expected 1/000", pix_out_valid, {red, green, blue});
    end
    @(negedge Clk);
    n_checks++;
    if (pix_out_valid !== 1'b1 || {red, green, blue} !== 12'hABC) begin
      n_fail++;
      $display("FAIL rdw_new: got v=%b rgb=%h expected 1/ABC", pix_out_valid, {red, green, blue});
    end
    @(negedge Clk);
  endtask

  task automatic read_entry(input string tag, input logic [1:0] bank, input logic [3:0] idx,
                            input logic [11:0] exp_rgb);
    pix_valid = 1'b1;
    pix_bank  = bank;
    pix_index = idx;
    @(negedge Clk);
    pix_valid = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (pix_out_valid !== 1'b1 || {red, green, blue} !== exp_rgb) begin
      n_fail++;
      $display("FAIL %s: got v=%b rgb=%h expected 1/%h", tag, pix_out_valid, {red, green, blue},
               exp_rgb);
    end
  endtask

  task automatic test_fade();
    wr_valid = 1'b1;
    wr_bank  = 2'd3;
    wr_index = 4'd1;
    wr_data  = 12'hFFF;
    @(negedge Clk);
    wr_valid    = 1'b0;
    fade_start  = 1'b1;
    fade_target = 5'd8;
    @(negedge Clk);
    fade_start = 1'b0;
`ifdef SPRITE_PALETTE_FADE_EN
    begin
      int busy_cycles = 0;
      for (int k = 1; k < 100 && fade_busy === 1'b1; k++) begin
        busy_cycles++;
        n_checks++;
        if (fade_level !== 5'(16 - (k - 1) / 4)) begin
          n_fail++;
          $display("FAIL fade_step_%0d: got level=%0d expected %0d", k, fade_level,
                   16 - (k - 1) / 4);
        end
        @(negedge Clk);
      end
      n_checks++;
      if (busy_cycles != 32 || fade_level !== 5'd8) begin
        n_fail++;
        $display("FAIL fade_done: got %0d busy cycles level=%0d expected 32/8", busy_cycles,
                 fade_level);
      end
      read_entry("fade_scaled", 2'd3, 4'd1, 12'h777);
      fade_start  = 1'b1;
      fade_target = 5'd8;
      @(negedge Clk);
      fade_start = 1'b0;
      n_checks++;
      if (fade_busy !== 1'b0 || fade_level !== 5'd8) begin
        n_fail++;
        $display("FAIL fade_same_target: got busy=%b level=%0d expected 0/8", fade_busy,
                 fade_level);
      end
      fade_start  = 1'b1;
      fade_target = 5'd20;
      @(negedge Clk);
      fade_start = 1'b0;
      n_checks++;
      if (fade_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fade_up_busy: got busy=%b expected 1", fade_busy);
      end
      repeat (4) @(negedge Clk);
      n_checks++;
      if (fade_level !== 5'd9) begin
        n_fail++;
        $display("FAIL fade_up_step: got level=%0d expected 9", fade_level);
      end
      for (int k = 0; k < 100 && fade_busy === 1'b1; k++) @(negedge Clk);
      n_checks++;
      if (fade_busy !== 1'b0 || fade_level !== 5'd16) begin
        n_fail++;
        $display("FAIL fade_clamp: got busy=%b level=%0d expected 0/16", fade_busy, fade_level);
      end
    end
`else
    repeat (40) @(negedge Clk);
    n_checks++;
    if (fade_level !== 5'd16 || fade_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fade_disabled: got level=%0d busy=%b expected 16/0", fade_level, fade_busy);
    end
`endif
    read_entry("fade_unity", 2'd3, 4'd1, 12'hFFF);
  endtask

  task automatic test_reset_mid();
    int busy_cycles;
    fade_start  = 1'b1;
    fade_target = 5'd0;
    @(negedge Clk);
    fade_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wr_valid  = 1'b1;
      wr_bank   = 2'd0;
      wr_index  = 4'(k);
      wr_data   = 12'h5A5;
      pix_valid = 1'b1;
      pix_bank  = 2'd2;
      pix_index = 4'd5;
      @(negedge Clk);
    end
    #2 Reset_n = 1'b0;
    #1 check_reset_values("mid_reset");
    clear_inputs();
    repeat (2) @(negedge Clk);
    Reset_n     = 1'b1;
    fade_start  = 1'b1;
    fade_target = 5'd0;
    run_init("mid_reset", busy_cycles);
    n_checks++;
    if (busy_cycles != 64) begin
      n_fail++;
      $display("FAIL reinit_length: got %0d cycles expected 64", busy_cycles);
    end
    read_entry("cleared_stream", 2'd0, 4'd2, 12'h000);
    read_entry("cleared_f91", 2'd2, 4'd5, 12'h000);
    n_checks++;
    if (fade_level !== 5'd16 || fade_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fade_after_reset: got level=%0d busy=%b expected 16/0", fade_level,
               fade_busy);
    end
  endtask

  initial begin
    clear_inputs();
    Reset_n = 1'b0;
    @(negedge Clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_during_write();
    test_fade();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
